// File: rtl/tea_stream_ctrl.sv
// Stream front-end for the register-mapped TEA core: programs key/data/control words,
// waits for the core to finish, reads the 64-bit result back and presents it downstream.
module tea_stream_ctrl #(
   parameter logic [31:0] CTRL_ENC     = 32'h1,
   parameter logic [31:0] CTRL_DEC     = 32'h2,
   parameter int unsigned BUSY_TIMEOUT = 8,
   parameter int unsigned DONE_TIMEOUT = 255
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         i_blk_valid,
   input  logic [63:0]  i_blk_data,
   input  logic         i_blk_dec,
   input  logic [127:0] i_key,
   output logic         o_blk_ready,
   output logic         o_res_valid,
   output logic [63:0]  o_res_data,
   input  logic         i_res_ready,
   output logic [3:0]   o_core_addr,
   output logic [31:0]  o_core_wdata,
   output logic         o_core_we,
   input  logic [31:0]  i_core_rdata,
   input  logic         i_core_ready,
   output logic         o_err,
   input  logic         i_err_clr
);

   localparam int unsigned MAX_TO = (BUSY_TIMEOUT > DONE_TIMEOUT) ? BUSY_TIMEOUT : DONE_TIMEOUT;
   localparam int unsigned CNT_W  = $clog2(MAX_TO + 1);

   typedef enum logic [3:0] {
      IDLE, WR_KEY, WR_DATA, WR_CTRL, WAIT_BUSY, WAIT_DONE, RD0, RD1, RD2, OUT
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         sub_q, sub_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [63:0]        data_q, data_d;
   logic               dec_q, dec_d;
   logic [127:0]       key_q, key_d;
   logic [127:0]       kc_q, kc_d;
   logic               kv_q, kv_d;
   logic [63:0]        res_q, res_d;
   logic               err_q, err_d;
   logic [3:0]         addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               we_q, we_d;
   logic               blk_ready_q, blk_ready_d;
   logic               res_valid_q, res_valid_d;
   logic               timeout;

   always_comb begin
      state_d = state_q;
      sub_d   = sub_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      dec_d   = dec_q;
      key_d   = key_q;
      kc_d    = kc_q;
      kv_d    = kv_q;
      res_d   = res_q;
      err_d   = err_q;
      addr_d  = '0;
      wdata_d = '0;
      we_d    = 1'b0;
      timeout = 1'b0;

      if (i_err_clr)
         err_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_blk_valid && blk_ready_q) begin
               data_d  = i_blk_data;
               dec_d   = i_blk_dec;
               key_d   = i_key;
               sub_d   = '0;
               state_d = (!kv_q || (i_key != kc_q)) ? WR_KEY : WR_DATA;
            end
         end
         WR_KEY: begin
            if (sub_q == 2'd3) begin
               kc_d    = key_q;
               kv_d    = 1'b1;
               sub_d   = '0;
               state_d = WR_DATA;
            end else begin
               sub_d = sub_q + 2'd1;
            end
         end
         WR_DATA: begin
            if (sub_q == 2'd1) begin
               sub_d   = '0;
               state_d = WR_CTRL;
            end else begin
               sub_d = sub_q + 2'd1;
            end
         end
         WR_CTRL: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         // Ready still high here just means the core has not yet seen the control write.
         WAIT_BUSY: begin
            if (!i_core_ready) begin
               cnt_d   = '0;
               state_d = WAIT_DONE;
            end else if (cnt_q == CNT_W'(BUSY_TIMEOUT)) begin
               timeout = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (i_core_ready) begin
               state_d = RD0;
            end else if (cnt_q == CNT_W'(DONE_TIMEOUT)) begin
               timeout = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RD0: state_d = RD1;
         RD1: begin
            res_d[63:32] = i_core_rdata;
            state_d      = RD2;
         end
         RD2: begin
            res_d[31:0] = i_core_rdata;
            state_d     = OUT;
         end
         OUT: begin
            if (i_res_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (timeout) begin
         err_d   = 1'b1;
         kv_d    = 1'b0;
         state_d = IDLE;
      end

      // Bus outputs are registered, so they are derived from the state being entered.
      unique case (state_d)
         WR_KEY: begin
            we_d   = 1'b1;
            addr_d = 4'd2 + {2'b00, sub_d};
            unique case (sub_d)
               2'd0:    wdata_d = key_d[127:96];
               2'd1:    wdata_d = key_d[95:64];
               2'd2:    wdata_d = key_d[63:32];
               default: wdata_d = key_d[31:0];
            endcase
         end
         WR_DATA: begin
            we_d    = 1'b1;
            addr_d  = {3'b000, sub_d[0]};
            wdata_d = sub_d[0] ? data_d[31:0] : data_d[63:32];
         end
         WR_CTRL: begin
            we_d    = 1'b1;
            addr_d  = 4'h6;
            wdata_d = dec_d ? CTRL_DEC : CTRL_ENC;
         end
         RD0:     addr_d = 4'h7;
         RD1:     addr_d = 4'h8;
         default: ;
      endcase

      blk_ready_d = (state_d == IDLE) && !err_d;
      res_valid_d = (state_d == OUT);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= IDLE;
         sub_q       <= '0;
         cnt_q       <= '0;
         data_q      <= '0;
         dec_q       <= 1'b0;
         key_q       <= '0;
         kc_q        <= '0;
         kv_q        <= 1'b0;
         res_q       <= '0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         blk_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sub_q       <= sub_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         dec_q       <= dec_d;
         key_q       <= key_d;
         kc_q        <= kc_d;
         kv_q        <= kv_d;
         res_q       <= res_d;
         err_q       <= err_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         blk_ready_q <= blk_ready_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign o_blk_ready  = blk_ready_q;
   assign o_res_valid  = res_valid_q;
   assign o_res_data   = res_q;
   assign o_core_addr  = addr_q;
   assign o_core_wdata = wdata_q;
   assign o_core_we    = we_q;
   assign o_err        = err_q;

endmodule

// File: tb/tb_tea_stream_ctrl.sv
// Bench for tea_stream_ctrl: behavioural TEA core on the word bus, scoreboard on the result stream.
module tb_tea_stream_ctrl;

   logic         i_clk = 1'b0;
   logic         i_rstn;
   logic         i_blk_valid;
   logic [63:0]  i_blk_data;
   logic         i_blk_dec;
   logic [127:0] i_key;
   logic         o_blk_ready;
   logic         o_res_valid;
   logic [63:0]  o_res_data;
   logic         i_res_ready;
   logic [3:0]   o_core_addr;
   logic [31:0]  o_core_wdata;
   logic         o_core_we;
   logic [31:0]  core_rdata = '0;
   logic         core_ready = 1'b1;
   logic         o_err;
   logic         i_err_clr;

   tea_stream_ctrl #(
      .CTRL_ENC(32'h1),
      .CTRL_DEC(32'h2),
      .BUSY_TIMEOUT(8),
      .DONE_TIMEOUT(255)
   ) dut (
      .i_clk(i_clk),
      .i_rstn(i_rstn),
      .i_blk_valid(i_blk_valid),
      .i_blk_data(i_blk_data),
      .i_blk_dec(i_blk_dec),
      .i_key(i_key),
      .o_blk_ready(o_blk_ready),
      .o_res_valid(o_res_valid),
      .o_res_data(o_res_data),
      .i_res_ready(i_res_ready),
      .o_core_addr(o_core_addr),
      .o_core_wdata(o_core_wdata),
      .o_core_we(o_core_we),
      .i_core_rdata(core_rdata),
      .i_core_ready(core_ready),
      .o_err(o_err),
      .i_err_clr(i_err_clr)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q[$];
   int kw_cnt  = 0;
   int acc_cnt = 0;

   // Reference TEA, used both by the core model and for expected values of non-trivial vectors
   function automatic logic [63:0] tea(input logic [63:0] blk, input logic [127:0] k, input bit dec);
      logic [31:0] v0, v1, sum, k0, k1, k2, k3;
      v0 = blk[63:32]; v1 = blk[31:0];
      k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
      if (!dec) begin
         sum = 32'h0;
         for (int unsigned i = 0; i < 32; i++) begin
            sum = sum + 32'h9E3779B9;
            v0  = v0 + ((((v1 << 4) + k0) ^ (v1 + sum)) ^ ((v1 >> 5) + k1));
            v1  = v1 + ((((v0 << 4) + k2) ^ (v0 + sum)) ^ ((v0 >> 5) + k3));
         end
      end else begin
         sum = 32'hC6EF3720;
         for (int unsigned i = 0; i < 32; i++) begin
            v1  = v1 - ((((v0 << 4) + k2) ^ (v0 + sum)) ^ ((v0 >> 5) + k3));
            v0  = v0 - ((((v1 << 4) + k0) ^ (v1 + sum)) ^ ((v1 >> 5) + k1));
            sum = sum - 32'h9E3779B9;
         end
      end
      return {v0, v1};
   endfunction

   // Core model: not reset by i_rstn, drops ready the cycle after a control write
   logic [31:0] mem [16];
   int          busy_cnt    = 0;
   int          run_len     = 5;
   bit          stuck_ready = 1'b0;
   logic [63:0] core_res;

   initial for (int i = 0; i < 16; i++) mem[i] = '0;

   always @(posedge i_clk) begin
      core_rdata <= mem[o_core_addr];
      if (o_core_we)
         mem[o_core_addr] <= o_core_wdata;
      if (o_core_we && o_core_addr == 4'h6) begin
         if (!stuck_ready) begin
            core_ready <= 1'b0;
            busy_cnt   <= run_len;
         end
      end else if (!core_ready) begin
         if (busy_cnt == 0) begin
            if (mem[6] == 32'h1)
               core_res = tea({mem[0], mem[1]}, {mem[2], mem[3], mem[4], mem[5]}, 1'b0);
            else if (mem[6] == 32'h2)
               core_res = tea({mem[0], mem[1]}, {mem[2], mem[3], mem[4], mem[5]}, 1'b1);
            else
               core_res = 64'hDEADBEEF_DEADBEEF;
            mem[7]     <= core_res[63:32];
            mem[8]     <= core_res[31:0];
            core_ready <= 1'b1;
         end else begin
            busy_cnt <= busy_cnt - 1;
         end
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: bus activity counters and result scoreboard, sampled mid-cycle
   always @(negedge i_clk) begin
      if (i_rstn) begin
         if (o_core_we && o_core_addr >= 4'h2 && o_core_addr <= 4'h5)
            kw_cnt++;
         if (o_core_we || o_core_addr != 4'h0)
            acc_cnt++;
         if (o_res_valid && i_res_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got %0h expected no result", o_res_data);
            end else begin
               check("result", o_res_data, exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [63:0] d, input bit dec, input logic [127:0] k);
      int n = 0;
      while (!o_blk_ready && n < 400) begin tick(); n++; end
      if (!o_blk_ready) check("blk_ready_wait", o_blk_ready, 1'b1);
      i_blk_valid = 1'b1;
      i_blk_data  = d;
      i_blk_dec   = dec;
      i_key       = k;
      tick();
      // Scramble inputs after acceptance; the DUT must use the latched copies
      i_blk_valid = 1'b0;
      i_blk_data  = ~d;
      i_blk_dec   = ~dec;
      i_key       = ~k;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 600) begin tick(); n++; end
      check({name, "_drain"}, exp_q.size(), 0);
   endtask

   localparam logic [127:0] K1 = 128'h1;
   localparam logic [63:0]  P3 = 64'h01234567_89ABCDEF;
   localparam logic [63:0]  P5 = 64'hFFFFFFFF_00000001;
   localparam logic [63:0]  P6 = 64'hCAFEF00D_12345678;

   initial begin
      logic [63:0] held;
      bit stable, rdy_seen;
      int n;

      i_rstn = 1'b0; i_blk_valid = 1'b0; i_blk_data = '0; i_blk_dec = 1'b0;
      i_key = '0; i_res_ready = 1'b1; i_err_clr = 1'b0;
      repeat (3) tick();
      check("rst_blk_ready", o_blk_ready, 1'b1);
      check("rst_res_valid", o_res_valid, 1'b0);
      check("rst_err", o_err, 1'b0);
      check("rst_core_we", o_core_we, 1'b0);
      check("rst_res_data", o_res_data, 64'h0);
      i_rstn = 1'b1;
      tick();

      // Known TEA vector, key cache cold
      kw_cnt = 0;
      exp_q.push_back(64'h41EA3A0A_94BAA940);
      send(64'h0, 1'b0, 128'h0);
      drain("enc_key0");
      check("enc_key0_keywr", kw_cnt, 4);

      // Same key, decrypt: cache hit
      kw_cnt = 0;
      exp_q.push_back(64'h0);
      send(64'h41EA3A0A_94BAA940, 1'b1, 128'h0);
      drain("dec_key0");
      check("dec_key0_keywr", kw_cnt, 0);

      // Key bit 0 changed
      kw_cnt = 0;
      exp_q.push_back(tea(P3, K1, 1'b0));
      send(P3, 1'b0, K1);
      drain("enc_k1");
      check("enc_k1_keywr", kw_cnt, 4);

      // Back-pressure on the result stream
      kw_cnt = 0;
      i_res_ready = 1'b0;
      exp_q.push_back(tea(P3, K1, 1'b1));
      send(P3, 1'b1, K1);
      n = 0;
      while (!o_res_valid && n < 600) begin tick(); n++; end
      check("bp_valid", o_res_valid, 1'b1);
      held = o_res_data; acc_cnt = 0; stable = 1'b1; rdy_seen = 1'b0;
      repeat (20) begin
         tick();
         if (o_res_data !== held || !o_res_valid) stable = 1'b0;
         if (o_blk_ready) rdy_seen = 1'b1;
      end
      check("bp_stable", stable, 1'b1);
      check("bp_blk_ready", rdy_seen, 1'b0);
      check("bp_core_access", acc_cnt, 0);
      check("bp_keywr", kw_cnt, 0);
      i_res_ready = 1'b1;
      drain("bp");

      // Core never goes busy: busy timeout
      stuck_ready = 1'b1;
      send(P5, 1'b0, K1);
      n = 0;
      while (!o_err && n < 60) begin tick(); n++; end
      check("to_err", o_err, 1'b1);
      check("to_blk_ready", o_blk_ready, 1'b0);
      repeat (5) tick();
      check("to_err_sticky", o_err, 1'b1);
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      check("clr_err", o_err, 1'b0);
      check("clr_blk_ready", o_blk_ready, 1'b1);
      stuck_ready = 1'b0;
      kw_cnt = 0;
      exp_q.push_back(tea(P5, K1, 1'b0));
      send(P5, 1'b0, K1);
      drain("after_to");
      check("after_to_keywr", kw_cnt, 4);

      // Reset while waiting for the core to finish
      run_len = 30;
      send(P6, 1'b0, K1);
      n = 0;
      while (core_ready && n < 40) begin tick(); n++; end
      check("rst_core_busy", core_ready, 1'b0);
      repeat (3) tick();
      i_rstn = 1'b0;
      #1;
      check("midrst_blk_ready", o_blk_ready, 1'b1);
      check("midrst_res_valid", o_res_valid, 1'b0);
      check("midrst_core_we", o_core_we, 1'b0);
      check("midrst_core_addr", o_core_addr, 4'h0);
      check("midrst_res_data", o_res_data, 64'h0);
      repeat (2) tick();
      i_rstn = 1'b1;
      n = 0;
      while (!core_ready && n < 80) begin tick(); n++; end
      check("midrst_core_done", core_ready, 1'b1);
      run_len = 5;
      kw_cnt = 0;
      exp_q.push_back(tea(P6, K1, 1'b0));
      send(P6, 1'b0, K1);
      drain("after_rst");
      check("after_rst_keywr", kw_cnt, 4);

      repeat (5) tick();
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
